// File: rtl/hash_bits_off_chunked.sv
// Chunked Hamming-distance counter with best-result tracking.
// Accepts one XOR vector (candidate hash ^ target) per handshake, counts its
// set bits CHUNK_WIDTH bits per clock, reports the count with its tag, and
// keeps the lowest count seen (plus its tag) until cleared.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a vector, ready_o high
// COUNT  | adding one chunk per cycle, ready_o low, valid_i ignored
// DONE   | result just published (done_o), best compared, ready_o high
module hash_bits_off_chunked #(
  parameter  int HASH_WIDTH  = 1024,
  parameter  int CHUNK_WIDTH = 32,
  parameter  int TAG_WIDTH   = 64,
  localparam int NUM_CHUNKS  = HASH_WIDTH / CHUNK_WIDTH,
  localparam int COUNT_WIDTH = $clog2(HASH_WIDTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [HASH_WIDTH-1:0]  hash_xor_i,
  input  logic [TAG_WIDTH-1:0]   tag_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   clear_best_i,
  output logic [COUNT_WIDTH-1:0] hash_bits_off_o,
  output logic [TAG_WIDTH-1:0]   tag_o,
  output logic                   done_o,
  output logic                   best_valid_o,
  output logic [COUNT_WIDTH-1:0] best_bits_off_o,
  output logic [TAG_WIDTH-1:0]   best_tag_o,
  output logic                   new_best_o
);

  localparam int PC_WIDTH  = $clog2(CHUNK_WIDTH + 1);
  // Keep the chunk counter at least one bit wide so NUM_CHUNKS == 1 still elaborates.
  localparam int CNT_WIDTH = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CHUNK = CNT_WIDTH'(NUM_CHUNKS - 1);

  generate
    if ((HASH_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_chunk
      $error("hash_bits_off_chunked: CHUNK_WIDTH must divide HASH_WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [HASH_WIDTH-1:0]  r_shift;
  logic [HASH_WIDTH-1:0]  w_shift_nxt;
  logic [TAG_WIDTH-1:0]   r_tag_pend;
  logic [COUNT_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0]   r_chunk;

  logic [COUNT_WIDTH-1:0] r_bits_off;
  logic [TAG_WIDTH-1:0]   r_tag_out;

  logic                   r_best_valid;
  logic [COUNT_WIDTH-1:0] r_best_bits;
  logic [TAG_WIDTH-1:0]   r_best_tag;

  logic                   w_accept;
  logic                   w_counting;
  logic                   w_last;
  logic [PC_WIDTH-1:0]    w_chunk_pc;
  logic [COUNT_WIDTH-1:0] w_acc_sum;
  logic                   w_update_best;

  function automatic logic [PC_WIDTH-1:0] popcount_chunk(input logic [CHUNK_WIDTH-1:0] bits);
    logic [PC_WIDTH-1:0] sum;
    sum = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      sum = sum + PC_WIDTH'(bits[i]);
    end
    return sum;
  endfunction

  assign ready_o    = (r_state != ST_COUNT);
  assign done_o     = (r_state == ST_DONE);
  assign w_accept   = valid_i && ready_o;
  assign w_counting = (r_state == ST_COUNT);
  assign w_last     = (r_chunk == '0);
  assign w_chunk_pc = popcount_chunk(r_shift[CHUNK_WIDTH-1:0]);
  assign w_acc_sum  = r_acc + COUNT_WIDTH'(w_chunk_pc);

  // With a single chunk the whole vector is consumed in one step, so the shift
  // would be by the full width; make that explicit instead of relying on it.
  generate
    if (NUM_CHUNKS > 1) begin : g_shift
      assign w_shift_nxt = r_shift >> CHUNK_WIDTH;
    end else begin : g_no_shift
      assign w_shift_nxt = '0;
    end
  endgenerate

  // A clear in the DONE cycle makes the completing result win unconditionally.
  assign w_update_best = (r_state == ST_DONE) &&
                         (clear_best_i || !r_best_valid || (r_bits_off < r_best_bits));
  assign new_best_o    = w_update_best;

  assign hash_bits_off_o = r_bits_off;
  assign tag_o           = r_tag_out;
  assign best_valid_o    = r_best_valid;
  assign best_bits_off_o = r_best_bits;
  assign best_tag_o      = r_best_tag;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (valid_i) w_state_nxt = ST_COUNT;
      ST_COUNT: if (w_last)  w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = valid_i ? ST_COUNT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Counting datapath: load on accept, then one chunk per COUNT cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_shift    <= '0;
      r_tag_pend <= '0;
      r_acc      <= '0;
      r_chunk    <= '0;
    end else if (w_accept) begin
      r_shift    <= hash_xor_i;
      r_tag_pend <= tag_i;
      r_acc      <= '0;
      r_chunk    <= LAST_CHUNK;
    end else if (w_counting) begin
      r_shift    <= w_shift_nxt;
      r_acc      <= w_acc_sum;
      r_chunk    <= r_chunk - 1'b1;
    end
  end

  // Publish the final count and its tag on the edge entering DONE; hold otherwise.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_bits_off <= '0;
      r_tag_out  <= '0;
    end else if (w_counting && w_last) begin
      r_bits_off <= w_acc_sum;
      r_tag_out  <= r_tag_pend;
    end
  end

  // Best record: load on the edge ending DONE when the result wins, else honour a clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_best_valid <= 1'b0;
      r_best_bits  <= '0;
      r_best_tag   <= '0;
    end else if (w_update_best) begin
      r_best_valid <= 1'b1;
      r_best_bits  <= r_bits_off;
      r_best_tag   <= r_tag_out;
    end else if (clear_best_i) begin
      r_best_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hash_bits_off_chunked.sv
// Directed bench for hash_bits_off_chunked: default geometry plus the
// single-chunk (CHUNK_WIDTH=1024) and bit-serial (CHUNK_WIDTH=1) variants.
module tb_hash_bits_off_chunked;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1023:0] hash;
  logic [63:0]   tag;
  logic          v0, v1, v2, clr;

  logic          r0, d0, nb0, bv0;
  logic [10:0]   cnt0, bb0;
  logic [63:0]   t0, bt0;
  logic          r1, d1, nb1, bv1;
  logic [10:0]   cnt1, bb1;
  logic [63:0]   t1, bt1;
  logic          r2, d2, nb2, bv2;
  logic [10:0]   cnt2, bb2;
  logic [63:0]   t2, bt2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hash_bits_off_chunked dut0 (
    .clk_i(clk), .rst_ni(rst_n), .hash_xor_i(hash), .tag_i(tag), .valid_i(v0),
    .ready_o(r0), .clear_best_i(clr), .hash_bits_off_o(cnt0), .tag_o(t0), .done_o(d0),
    .best_valid_o(bv0), .best_bits_off_o(bb0), .best_tag_o(bt0), .new_best_o(nb0));

  hash_bits_off_chunked #(.CHUNK_WIDTH(1024)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .hash_xor_i(hash), .tag_i(tag), .valid_i(v1),
    .ready_o(r1), .clear_best_i(clr), .hash_bits_off_o(cnt1), .tag_o(t1), .done_o(d1),
    .best_valid_o(bv1), .best_bits_off_o(bb1), .best_tag_o(bt1), .new_best_o(nb1));

  hash_bits_off_chunked #(.CHUNK_WIDTH(1)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .hash_xor_i(hash), .tag_i(tag), .valid_i(v2),
    .ready_o(r2), .clear_best_i(clr), .hash_bits_off_o(cnt2), .tag_o(t2), .done_o(d2),
    .best_valid_o(bv2), .best_bits_off_o(bb2), .best_tag_o(bt2), .new_best_o(nb2));

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [1023:0] ones_low(input int n);
    logic [1023:0] all;
    all = '1;
    if (n == 0) return '0;
    return all >> (1024 - n);
  endfunction

  function automatic int ref_pop(input logic [1023:0] v);
    int s = 0;
    for (int i = 0; i < 1024; i++) s += int'(v[i]);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done_o of dut0; ready_o must track done_o while counting.
  task automatic wait_done0(output int n);
    n = 0;
    while (d0 !== 1'b1 && n < 100) begin
      step();
      n++;
      chk("ready_vs_state", {63'd0, r0}, {63'd0, d0});
    end
  endtask

  // Offers one vector to dut0 and checks the DONE-cycle outputs; returns in DONE.
  task automatic go0(input logic [1023:0] vec, input logic [63:0] tg,
                     input int exp_cnt, input logic exp_nb, input string name);
    int n;
    hash = vec; tag = tg; v0 = 1'b1;
    chk({name, "_ready"}, {63'd0, r0}, 64'd1);
    step();
    v0 = 1'b0;
    wait_done0(n);
    chk({name, "_latency"}, 64'(n), 64'd32);
    chk({name, "_count"}, {53'd0, cnt0}, 64'(exp_cnt));
    chk({name, "_tag"}, t0, tg);
    chk({name, "_new_best"}, {63'd0, nb0}, {63'd0, exp_nb});
  endtask

  logic [1023:0] vec_b2b [4];
  logic [63:0]   tag_b2b [4];
  int            cnt_b2b [4];
  logic          nb_b2b  [4];

  initial begin
    logic [1023:0] m;
    logic [1023:0] rv;
    int n, ep;

    rst_n = 1'b0; v0 = 0; v1 = 0; v2 = 0; clr = 0; hash = '0; tag = '0;
    step(); step();
    chk("rst_count", {53'd0, cnt0}, 64'd0);
    chk("rst_tag", t0, 64'd0);
    chk("rst_done", {63'd0, d0}, 64'd0);
    chk("rst_best_valid", {63'd0, bv0}, 64'd0);
    chk("rst_best_bits", {53'd0, bb0}, 64'd0);
    chk("rst_best_tag", bt0, 64'd0);
    chk("rst_new_best", {63'd0, nb0}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", {63'd0, r0}, 64'd1);

    // All-zero vector becomes the first best.
    go0('0, 64'h1, 0, 1'b1, "zero");
    step();
    chk("zero_done_pulse", {63'd0, d0}, 64'd0);
    chk("zero_best_bits", {53'd0, bb0}, 64'd0);
    chk("zero_best_tag", bt0, 64'h1);
    chk("zero_best_valid", {63'd0, bv0}, 64'd1);

    go0('1, 64'h3, 1024, 1'b0, "ones");
    m = '0; m[1023] = 1'b1;
    go0(m, 64'h2, 1, 1'b0, "msb");
    go0(1024'd1, 64'h4, 1, 1'b0, "lsb");
    step();
    chk("best_kept_bits", {53'd0, bb0}, 64'd0);
    chk("best_kept_tag", bt0, 64'h1);

    clr = 1'b1; step(); clr = 1'b0;
    chk("clear_idle", {63'd0, bv0}, 64'd0);

    // Back-to-back stream with valid held: 500, 300, 300, 700.
    vec_b2b = '{ones_low(500), ones_low(300), ~ones_low(724), ones_low(700)};
    tag_b2b = '{64'hA, 64'hB, 64'hC, 64'hD};
    cnt_b2b = '{500, 300, 300, 700};
    nb_b2b  = '{1'b1, 1'b1, 1'b0, 1'b0};
    hash = vec_b2b[0]; tag = tag_b2b[0]; v0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_ready", {63'd0, r0}, 64'd1);
      step();
      wait_done0(n);
      chk("b2b_spacing", 64'(n + ((i == 0) ? 0 : 1)), (i == 0) ? 64'd32 : 64'd33);
      chk("b2b_count", {53'd0, cnt0}, 64'(cnt_b2b[i]));
      chk("b2b_tag", t0, tag_b2b[i]);
      chk("b2b_new_best", {63'd0, nb0}, {63'd0, nb_b2b[i]});
      if (i < 3) begin
        hash = vec_b2b[i+1]; tag = tag_b2b[i+1];
      end else begin
        v0 = 1'b0;
      end
    end
    step();
    chk("b2b_idle_ready", {63'd0, r0}, 64'd1);
    chk("b2b_best_bits", {53'd0, bb0}, 64'd300);
    chk("b2b_best_tag", bt0, 64'hB);

    // Clear coincident with DONE of a worse result.
    go0(ones_low(700), 64'hE, 700, 1'b0, "clr_done");
    clr = 1'b1; #1;
    chk("clr_done_new_best", {63'd0, nb0}, 64'd1);
    step(); clr = 1'b0;
    chk("clr_done_best_bits", {53'd0, bb0}, 64'd700);
    chk("clr_done_best_tag", bt0, 64'hE);
    chk("clr_done_best_valid", {63'd0, bv0}, 64'd1);

    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_alone_valid", {63'd0, bv0}, 64'd0);
    go0(ones_low(900), 64'hF, 900, 1'b1, "after_clr");
    step();
    chk("after_clr_best_bits", {53'd0, bb0}, 64'd900);
    chk("after_clr_best_tag", bt0, 64'hF);

    // Reset mid-COUNT discards the in-flight hash.
    hash = ones_low(123); tag = 64'h77; v0 = 1'b1;
    step(); v0 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("abort_no_done", {63'd0, d0}, 64'd0);
    end
    rst_n = 1'b0; v0 = 1'b1; hash = ones_low(5); tag = 64'h55;
    step();
    chk("abort_count", {53'd0, cnt0}, 64'd0);
    chk("abort_tag", t0, 64'd0);
    chk("abort_best_valid", {63'd0, bv0}, 64'd0);
    chk("abort_best_bits", {53'd0, bb0}, 64'd0);
    chk("abort_best_tag", bt0, 64'd0);
    chk("abort_done", {63'd0, d0}, 64'd0);
    chk("abort_ready", {63'd0, r0}, 64'd1);
    rst_n = 1'b1;
    go0(ones_low(5), 64'h55, 5, 1'b1, "post_abort");
    step();

    // Single-chunk variant: done one edge after accept.
    for (int k = 0; k < 32; k++) rv[k*32 +: 32] = $urandom;
    ep = ref_pop(rv);
    hash = rv; tag = 64'h1234; v1 = 1'b1;
    chk("w1024_ready", {63'd0, r1}, 64'd1);
    step(); v1 = 1'b0;
    step();
    chk("w1024_done", {63'd0, d1}, 64'd1);
    chk("w1024_count", {53'd0, cnt1}, 64'(ep));
    chk("w1024_tag", t1, 64'h1234);
    chk("w1024_new_best", {63'd0, nb1}, 64'd1);
    step();
    chk("w1024_best_bits", {53'd0, bb1}, 64'(ep));
    chk("w1024_best_tag", bt1, 64'h1234);
    chk("w1024_best_valid", {63'd0, bv1}, 64'd1);

    // Bit-serial variant: done 1024 edges after accept.
    for (int k = 0; k < 32; k++) rv[k*32 +: 32] = $urandom;
    ep = ref_pop(rv);
    hash = rv; tag = 64'h5678; v2 = 1'b1;
    chk("w1_ready", {63'd0, r2}, 64'd1);
    step(); v2 = 1'b0;
    n = 0;
    while (d2 !== 1'b1 && n < 1100) begin
      step();
      n++;
    end
    chk("w1_latency", 64'(n), 64'd1024);
    chk("w1_count", {53'd0, cnt2}, 64'(ep));
    chk("w1_tag", t2, 64'h5678);
    chk("w1_new_best", {63'd0, nb2}, 64'd1);
    step();
    chk("w1_best_bits", {53'd0, bb2}, 64'(ep));
    chk("w1_best_tag", bt2, 64'h5678);
    chk("w1_best_valid", {63'd0, bv2}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
